// File: rtl/uart_pkg.sv
// Shared UART constants and receive-FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  // Baud divider shared with the transmit path: 50 MHz / 115200.
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive holding-buffer handshake and sticky error flags between uart_rx and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rdData;
  logic                      rdValid;
  logic                      rdAck;
  logic                      errClr;
  logic                      frameErr;
  logic                      overrun;

  modport master (
    output rdData, rdValid, frameErr, overrun,
    input  rdAck, errClr
  );

  modport slave (
    input  rdData, rdValid, frameErr, overrun,
    output rdAck, errClr
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk. No backpressure.
// Reset value is a parameter so idle-high or idle-low lines can both be handled.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a one-entry holding buffer with sticky framing/overrun flags.
// Latency: rdValid rises one clk after the stop-bit mid-sample (~9.5 bit times + 3 clk from line fall).
// Backpressure: none on the line; a byte completing while the buffer is full is dropped and flags overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rxPin,
  output logic        busy,
  uart_rx_if.master   rd
);

  if (CLKS_PER_BIT < 4) begin : g_chk_clks
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rxS;
  logic                      prevS;
  logic                      done;
  logic                      frame_set;
  logic                      ovr_set;

  // Reset-to-0 synchronizer: the line must be seen high before a start edge can register.
  sync2 #(.RST_VAL(1'b0)) u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (rxPin),
    .q     (rxS)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prevS <= 1'b0;
    else      prevS <= rxS;
  end

  assign busy      = (state != IDLE);
  assign frame_set = (state == STOP) && (cnt == '0) && !rxS;
  assign ovr_set   = done && rd.rdValid && !rd.rdAck;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (prevS && !rxS) begin
            cnt   <= HALF_BIT;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxS) begin
            state <= IDLE;
          end else begin
            cnt     <= FULL_BIT;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift <= {rxS, shift[UART_DATA_BITS-1:1]};
            cnt   <= FULL_BIT;
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxS) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= BREAK;
          end
        end
        BREAK: begin
          // Hold here until the line recovers so a held-low break cannot retrigger.
          if (rxS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd.rdData   <= '0;
      rd.rdValid  <= 1'b0;
      rd.frameErr <= 1'b0;
      rd.overrun  <= 1'b0;
    end else begin
      if (done && (!rd.rdValid || rd.rdAck)) begin
        rd.rdData  <= shift;
        rd.rdValid <= 1'b1;
      end else if (rd.rdAck) begin
        rd.rdValid <= 1'b0;
      end

      // A flag being set in the same cycle as errClr stays set.
      if (frame_set)      rd.frameErr <= 1'b1;
      else if (rd.errClr) rd.frameErr <= 1'b0;

      if (ovr_set)        rd.overrun <= 1'b1;
      else if (rd.errClr) rd.overrun <= 1'b0;
    end
  end

endmodule
